// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if
// Request/result bundle for the sequential ALU.
//   master (requester): drives start/control/in1/in2,
//                       observes busy/done/result/hi/zero/overflow/div_by_zero
//   slave  (alu_seq)  : the opposite direction of every signal
// WIDTH sets the operand/result width and must match the attached ALU.
// ---------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       control;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             overflow;
    logic             div_by_zero;

    modport master (
        output start, control, in1, in2,
        input  busy, done, result, hi, zero, overflow, div_by_zero
    );

    modport slave (
        input  start, control, in1, in2,
        output busy, done, result, hi, zero, overflow, div_by_zero
    );
endinterface

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Sequential ALU: single-cycle AND/OR/ADD/SUB/SLT/SLTU, plus an iterative
// unsigned shift-add multiplier and restoring divider (one bit per cycle).
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - alu_seq_if.slave: start/control/in1/in2 in,
//            busy/done/result/hi/zero/overflow/div_by_zero out
// Results and flags are registered and change only when entering FIN;
// done is high for the single FIN cycle.
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input logic     clk,
    input logic     rst_n,
    alu_seq_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_MULU = 4'b1001;
    localparam logic [3:0] OP_DIVU = 4'b1010;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_isDiv;
    // Iteration datapath: r_hiPart is the product high half / partial
    // remainder, r_lo is the multiplier / dividend shifting into quotient,
    // r_mcand is the multiplicand / divisor.
    logic [WIDTH-1:0] r_hiPart;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_mcand;

    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic             r_zero;
    logic             r_overflow;
    logic             r_divByZero;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_opResult;
    logic [WIDTH-1:0] w_opHi;
    logic             w_opOvf;
    logic             w_opDbz;
    logic             w_goCalc;

    logic [WIDTH:0]   w_mulSum;
    logic [WIDTH:0]   w_divShift;
    logic [WIDTH:0]   w_divTrial;
    logic [WIDTH-1:0] w_iterHi;
    logic [WIDTH-1:0] w_iterLo;
    logic [CNT_W-1:0] w_cntNext;

    // Single-cycle operation results, computed straight from the request so
    // they are captured on the accepting edge.
    always_comb begin
        w_sum      = bus.in1 + bus.in2;
        w_diff     = bus.in1 - bus.in2;
        w_opResult = '0;
        w_opHi     = '0;
        w_opOvf    = 1'b0;
        w_opDbz    = 1'b0;
        w_goCalc   = 1'b0;
        case (bus.control)
            OP_AND: w_opResult = bus.in1 & bus.in2;
            OP_OR:  w_opResult = bus.in1 | bus.in2;
            OP_ADD: begin
                w_opResult = w_sum;
                w_opOvf    = (bus.in1[WIDTH-1] == bus.in2[WIDTH-1]) &&
                             (w_sum[WIDTH-1] != bus.in1[WIDTH-1]);
            end
            OP_SUB: begin
                w_opResult = w_diff;
                w_opOvf    = (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) &&
                             (w_diff[WIDTH-1] != bus.in1[WIDTH-1]);
            end
            OP_SLT:  w_opResult = {{(WIDTH-1){1'b0}}, ($signed(bus.in1) < $signed(bus.in2))};
            OP_SLTU: w_opResult = {{(WIDTH-1){1'b0}}, (bus.in1 < bus.in2)};
            OP_MULU: w_goCalc = 1'b1;
            OP_DIVU: begin
                // Divide by zero finishes immediately with all-ones quotient
                // and the dividend as remainder.
                if (bus.in2 == '0) begin
                    w_opResult = '1;
                    w_opHi     = bus.in1;
                    w_opDbz    = 1'b1;
                end else begin
                    w_goCalc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // One multiply or divide step per cycle.
    always_comb begin
        w_mulSum   = {1'b0, r_hiPart} + {1'b0, (r_lo[0] ? r_mcand : {WIDTH{1'b0}})};
        w_divShift = {r_hiPart, r_lo[WIDTH-1]};
        w_divTrial = w_divShift - {1'b0, r_mcand};
        w_cntNext  = r_cnt + 1'b1;
        if (r_isDiv) begin
            // No borrow means the shifted remainder covered the divisor.
            if (!w_divTrial[WIDTH]) begin
                w_iterHi = w_divTrial[WIDTH-1:0];
                w_iterLo = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_iterHi = w_divShift[WIDTH-1:0];
                w_iterLo = {r_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_iterHi = w_mulSum[WIDTH:1];
            w_iterLo = {w_mulSum[0], r_lo[WIDTH-1:1]};
        end
    end

    // Control FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_isDiv     <= 1'b0;
            r_hiPart    <= '0;
            r_lo        <= '0;
            r_mcand     <= '0;
            r_result    <= '0;
            r_hi        <= '0;
            r_zero      <= 1'b1;
            r_overflow  <= 1'b0;
            r_divByZero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (w_goCalc) begin
                            r_state  <= S_CALC;
                            r_cnt    <= '0;
                            r_isDiv  <= (bus.control == OP_DIVU);
                            r_hiPart <= '0;
                            if (bus.control == OP_DIVU) begin
                                r_lo    <= bus.in1;
                                r_mcand <= bus.in2;
                            end else begin
                                r_lo    <= bus.in2;
                                r_mcand <= bus.in1;
                            end
                        end else begin
                            r_state     <= S_FIN;
                            r_result    <= w_opResult;
                            r_hi        <= w_opHi;
                            r_zero      <= (w_opResult == '0);
                            r_overflow  <= w_opOvf;
                            r_divByZero <= w_opDbz;
                        end
                    end
                end
                S_CALC: begin
                    r_hiPart <= w_iterHi;
                    r_lo     <= w_iterLo;
                    r_cnt    <= w_cntNext;
                    if (w_cntNext == CNT_W'(WIDTH)) begin
                        r_state     <= S_FIN;
                        r_result    <= w_iterLo;
                        r_hi        <= w_iterHi;
                        r_zero      <= (w_iterLo == '0);
                        r_overflow  <= 1'b0;
                        r_divByZero <= 1'b0;
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = (r_state == S_CALC) || (r_state == S_FIN);
    assign bus.done        = (r_state == S_FIN);
    assign bus.result      = r_result;
    assign bus.hi          = r_hi;
    assign bus.zero        = r_zero;
    assign bus.overflow    = r_overflow;
    assign bus.div_by_zero = r_divByZero;
endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Directed bench for alu_seq at WIDTH=32 with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_alu_seq;
    localparam int WIDTH = 32;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_MULU = 4'b1001;
    localparam logic [3:0] OP_DIVU = 4'b1010;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   busyDrops;
    int   doneCount;

    alu_seq_if #(.WIDTH(WIDTH)) bus ();

    alu_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request for exactly one rising edge; returns at the
    // falling edge after the accepting edge (cycle 1).
    task automatic applyStimulus(input logic [3:0] ctrl, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.control = ctrl;
        bus.in1     = a;
        bus.in2     = b;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    // Wait (bounded) for done, counting cycles from the accept edge.
    // With meddle set, start pulses and operands change while busy.
    task automatic waitDone(input int limit, input bit meddle, output int cycles, output int drops);
        cycles = 1;
        drops  = 0;
        while (bus.done !== 1'b1 && cycles < limit) begin
            if (bus.busy !== 1'b1) drops++;
            if (meddle) begin
                bus.start   = cycles[0];
                bus.control = OP_ADD;
                bus.in1     = 32'h1000 + cycles;
                bus.in2     = 32'h3;
            end
            @(negedge clk);
            cycles++;
        end
        bus.start = 1'b0;
        checkOutput("doneSeen", {63'd0, bus.done}, 64'd1);
    endtask

    task automatic checkFlags(input string tag, input logic [WIDTH-1:0] res, input logic [WIDTH-1:0] hiv,
                              input logic z, input logic ov, input logic dz);
        checkOutput({tag, ".result"}, {32'd0, bus.result}, {32'd0, res});
        checkOutput({tag, ".hi"}, {32'd0, bus.hi}, {32'd0, hiv});
        checkOutput({tag, ".zero"}, {63'd0, bus.zero}, {63'd0, z});
        checkOutput({tag, ".overflow"}, {63'd0, bus.overflow}, {63'd0, ov});
        checkOutput({tag, ".divByZero"}, {63'd0, bus.div_by_zero}, {63'd0, dz});
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.control = 4'd0;
        bus.in1     = '0;
        bus.in2     = '0;

        // Reset state
        #23;
        checkOutput("rst.busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("rst.done", {63'd0, bus.done}, 64'd0);
        checkFlags("rst", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD overflow, accepted on the first edge after reset release
        bus.start = 1'b1; bus.control = OP_ADD; bus.in1 = 32'h7FFFFFFF; bus.in2 = 32'h1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("add.done", {63'd0, bus.done}, 64'd1);
        checkFlags("add", 32'h80000000, 32'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("add.donePulse", {63'd0, bus.done}, 64'd0);
        checkOutput("add.idleBusy", {63'd0, bus.busy}, 64'd0);
        checkOutput("add.hold", {32'd0, bus.result}, 64'h80000000);

        applyStimulus(OP_SUB, 32'd5, 32'd5);
        checkOutput("sub.done", {63'd0, bus.done}, 64'd1);
        checkFlags("sub", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        applyStimulus(OP_SUB, 32'h80000000, 32'd1);
        checkFlags("subOvf", 32'h7FFFFFFF, 32'd0, 1'b0, 1'b1, 1'b0);

        applyStimulus(OP_SLT, 32'h80000000, 32'd1);
        checkFlags("slt", 32'd1, 32'd0, 1'b0, 1'b0, 1'b0);

        applyStimulus(OP_SLTU, 32'h80000000, 32'd1);
        checkFlags("sltu", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        applyStimulus(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
        checkOutput("and.result", {32'd0, bus.result}, 64'h00F0_1200);

        applyStimulus(OP_OR, 32'hF000_0001, 32'h0000_0100);
        checkOutput("or.result", {32'd0, bus.result}, 64'hF000_0101);

        applyStimulus(4'b1111, 32'h1234, 32'h5678);
        checkOutput("undef.done", {63'd0, bus.done}, 64'd1);
        checkFlags("undef", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        // MULU with interfering starts and operand changes while busy
        applyStimulus(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        waitDone(60, 1'b1, cyc, busyDrops);
        checkOutput("mulMax.cycles", 64'(cyc), 64'd33);
        checkOutput("mulMax.busyDrops", 64'(busyDrops), 64'd0);
        checkFlags("mulMax", 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("mulMax.noRequeue", {63'd0, bus.busy}, 64'd0);

        // zero tracks result only, hi is nonzero here
        applyStimulus(OP_MULU, 32'h00010000, 32'h00010000);
        waitDone(60, 1'b0, cyc, busyDrops);
        checkFlags("mulHi", 32'd0, 32'd1, 1'b1, 1'b0, 1'b0);

        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        waitDone(60, 1'b0, cyc, busyDrops);
        checkOutput("div.cycles", 64'(cyc), 64'd33);
        checkFlags("div", 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);

        applyStimulus(OP_DIVU, 32'hFFFFFFFF, 32'h00010000);
        waitDone(60, 1'b0, cyc, busyDrops);
        checkFlags("divBig", 32'h0000FFFF, 32'h0000FFFF, 1'b0, 1'b0, 1'b0);

        applyStimulus(OP_DIVU, 32'd100, 32'd0);
        checkOutput("div0.done", {63'd0, bus.done}, 64'd1);
        checkFlags("div0", 32'hFFFFFFFF, 32'd100, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a DIVU aborts it with no done afterwards
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        checkOutput("abort.busyBefore", {63'd0, bus.busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort.busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("abort.done", {63'd0, bus.done}, 64'd0);
        checkFlags("abort", 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) doneCount++;
        end
        checkOutput("abort.noDone", 64'(doneCount), 64'd0);

        // start held high: accepted every other cycle
        bus.start = 1'b1; bus.control = OP_ADD; bus.in1 = 32'd1; bus.in2 = 32'd2;
        doneCount = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) doneCount++;
            checkOutput("b2b.done", {63'd0, bus.done}, {63'd0, k[0]});
        end
        bus.start = 1'b0;
        checkOutput("b2b.count", 64'(doneCount), 64'd4);
        checkOutput("b2b.result", {32'd0, bus.result}, 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal 8..64, even).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, iteration counter width.
REQ-003 clk  input  1  rising-edge clock, sole clock domain.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request; operands and control sampled on the rising edge where start=1 and busy=0.
REQ-006 control  input  4  operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 SLTU, 1001 MULU, 1010 DIVU.
REQ-007 in1  input  WIDTH  operand A (dividend for DIVU).
REQ-008 in2  input  WIDTH  operand B (divisor for DIVU).
REQ-009 busy  output  1  high while an operation is in progress; new start ignored.
REQ-010 done  output  1  one-cycle pulse marking result/hi/flags valid.
REQ-011 result  output  WIDTH  primary result (MULU low half, DIVU quotient).
REQ-012 hi  output  WIDTH  MULU high half, DIVU remainder, 0 otherwise.
REQ-013 zero  output  1  high when result == 0.
REQ-014 overflow  output  1  signed overflow of ADD/SUB, 0 for other ops.
REQ-015 div_by_zero  output  1  high when DIVU completed with in2 == 0.

Function
REQ-016 SHALL implement FSM IDLE, CALC, FIN; IDLE->FIN on accepted single-cycle op; IDLE->CALC on accepted MULU/DIVU with in2!=0; CALC->FIN when iteration count reaches WIDTH; FIN->IDLE unconditionally.
REQ-017 busy SHALL be 1 in CALC and FIN states only.
REQ-018 done SHALL be 1 only in FIN; single-cycle ops: done one cycle after the accepting edge.
REQ-019 MULU SHALL be unsigned shift-add, one partial product per cycle, WIDTH iterations; done WIDTH+1 cycles after accept; {hi,result} = in1*in2 (2*WIDTH bits).
REQ-020 DIVU SHALL be unsigned restoring division, one quotient bit per cycle, WIDTH iterations, done WIDTH+1 cycles after accept; result = quotient, hi = remainder.
REQ-021 DIVU with in2==0 SHALL bypass CALC: result = all ones, hi = in1, div_by_zero=1, done one cycle after accept.
REQ-022 ADD/SUB SHALL wrap modulo 2^WIDTH; overflow = signed overflow of the operation.
REQ-023 SLT SHALL yield 1 if signed in1 < in2 (correct across overflow), else 0; SLTU unsigned compare; upper bits 0.
REQ-024 Undefined control codes SHALL complete as single-cycle ops with result=0, hi=0, zero=1, other flags 0.
REQ-025 Operands SHALL be latched at accept; input changes during busy SHALL NOT affect the result.
REQ-026 start while busy=1 SHALL be ignored, not queued; start in the cycle done=1 is ignored (busy=1), accepted on next cycle.
REQ-027 result, hi and all flags SHALL hold their last completed values until the next FIN; flags update only at FIN.
REQ-028 zero SHALL reflect result only, never hi.

Reset
REQ-029 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, result=0, hi=0, zero=1, overflow=0, div_by_zero=0, counter=0.
REQ-030 Reset asserted mid-CALC SHALL abort the operation; no done pulse follows release.
REQ-031 First start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification (WIDTH=32)
REQ-032 ADD 0x7FFFFFFF+0x00000001 -> done 1 cycle later, result 0x80000000, overflow 1, zero 0.
REQ-033 SUB 5-5 -> result 0, zero 1, overflow 0; SLT 0x80000000 vs 1 -> result 1; SLTU same operands -> result 0.
REQ-034 MULU 0xFFFFFFFF*0xFFFFFFFF -> busy 33 cycles, done at cycle 33, hi 0xFFFFFFFE, result 0x00000001.
REQ-035 DIVU 100/7 -> done at cycle 33, result 14, hi 2; DIVU 100/0 -> done at cycle 1, result 0xFFFFFFFF, hi 100, div_by_zero 1.
REQ-036 start pulses and operand changes during MULU -> ignored, result unchanged; rst_n low at cycle 10 of DIVU -> all outputs reset values, no done.
REQ-037 Back-to-back: start held high continuously with ADD -> accepts every other cycle, one done per accept.
